// File: rtl/apb2wb_bridge.sv
// APB slave to pipelined Wishbone master bridge: one Wishbone transfer per APB
// transfer, with stall handling, err/rty mapping to pslverr and a cycle timeout.
module apb2wb_bridge #(
    parameter int ADR_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             psel_i,
    input  logic             penable_i,
    input  logic             pwrite_i,
    input  logic [ADR_W-1:0] paddr_i,
    input  logic [31:0]      pwdata_i,
    input  logic [3:0]       pstrb_i,
    output logic             pready_o,
    output logic [31:0]      prdata_o,
    output logic             pslverr_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [ADR_W-1:2] wb_adr_o,
    output logic [3:0]       wb_sel_o,
    output logic [31:0]      wb_dat_o,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    input  logic             wb_rty_i,
    input  logic             wb_stall_i,
    input  logic [31:0]      wb_dat_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Last open cycle: the counter reaches TIMEOUT on the edge that leaves it.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             err_r;

    logic setup_s;
    logic resp_s;
    logic bus_err_s;
    logic term_s;
    logic expire_s;
    logic unused_s;

    assign unused_s = ^{paddr_i[1:0], err_r};

    // Decode APB setup, Wishbone termination and timeout expiry for this cycle.
    always_comb begin
        setup_s   = psel_i & ~penable_i;
        resp_s    = wb_ack_i | wb_err_i | wb_rty_i;
        bus_err_s = wb_err_i | wb_rty_i;
        term_s    = 1'b0;
        expire_s  = 1'b0;
        case (state_r)
            REQ: begin
                term_s = ~wb_stall_i & resp_s;
            end
            WAIT: begin
                term_s = resp_s;
            end
            default: begin
                term_s = 1'b0;
            end
        endcase
        if ((state_r == REQ || state_r == WAIT) && !term_s) begin
            expire_s = (cnt_r == CNT_LAST);
        end else begin
            expire_s = 1'b0;
        end
    end

    // Bridge FSM with all bus outputs registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            err_r     <= 1'b0;
            pready_o  <= 1'b0;
            pslverr_o <= 1'b0;
            prdata_o  <= 32'h0000_0000;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_sel_o  <= 4'h0;
            wb_dat_o  <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    pready_o  <= 1'b0;
                    pslverr_o <= 1'b0;
                    if (setup_s) begin
                        state_r  <= REQ;
                        cnt_r    <= '0;
                        err_r    <= 1'b0;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= pwrite_i;
                        wb_adr_o <= paddr_i[ADR_W-1:2];
                        wb_sel_o <= pstrb_i;
                        wb_dat_o <= pwdata_i;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ, WAIT: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (term_s) begin
                        state_r   <= DONE;
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        pready_o  <= 1'b1;
                        pslverr_o <= bus_err_s;
                        err_r     <= bus_err_s;
                        if (!wb_we_o) begin
                            prdata_o <= wb_dat_i;
                        end else begin
                            prdata_o <= prdata_o;
                        end
                    end else if (expire_s) begin
                        // Abandon the slave; read data is left untouched.
                        state_r   <= DONE;
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        pready_o  <= 1'b1;
                        pslverr_o <= 1'b1;
                        err_r     <= 1'b1;
                    end else if (state_r == REQ && !wb_stall_i) begin
                        state_r  <= WAIT;
                        wb_stb_o <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                DONE: begin
                    state_r   <= IDLE;
                    pready_o  <= 1'b0;
                    pslverr_o <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    wb_cyc_o  <= 1'b0;
                    wb_stb_o  <= 1'b0;
                    pready_o  <= 1'b0;
                    pslverr_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
